// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: funct3 size codes, FSM state, pipeline register layouts.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } mem_state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwrite;
  } mem_wb_t;

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_H, F3_HU: is_misaligned = a[0];
      F3_W:        is_misaligned = (a != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Store byte-lane replication / enables and load byte/half extraction with sign or zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h0, byte_sel};
      end
      F3_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, req/ack data-memory FSM, load alignment and MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them on misalign_mem.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResult_ex,
  input  logic [XLEN-1:0] MemWriteData_ex,
  input  logic [4:0]      rdAddr_ex,
  input  logic            RegWrite_ex,
  input  logic            MemRead_ex,
  input  logic            MemWrite_ex,
  input  logic [2:0]      funct3_ex,
  output logic [XLEN-1:0] ALUResult_mem,
  output logic [4:0]      rdAddr_mem,
  output logic            RegWrite_mem,
  output logic            stall_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            misalign_mem,
`endif
  output logic [XLEN-1:0] RegWriteData_wb,
  output logic [4:0]      rdAddr_wb,
  output logic            RegWrite_wb
);

  ex_mem_t    ex_mem_d, ex_mem_q;
  mem_wb_t    mem_wb_d, mem_wb_q;
  mem_state_e state_d, state_q;
  logic       misaligned;
  logic       ex_access;
  logic       is_load;
  logic [31:0] load_data;

  // A load only when not also a store.
  assign is_load = ex_mem_q.memread & ~ex_mem_q.memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_d, misalign_q;
  assign misaligned = (ex_mem_q.memread | ex_mem_q.memwrite)
                    & is_misaligned(ex_mem_q.funct3, ex_mem_q.alu[1:0]);
  assign ex_access  = (MemRead_ex | MemWrite_ex) & ~is_misaligned(funct3_ex, ALUResult_ex[1:0]);
  assign misalign_d = misaligned & ~stall_mem;
  assign misalign_mem = misalign_q;
`else
  assign misaligned = 1'b0;
  assign ex_access  = MemRead_ex | MemWrite_ex;
`endif

  assign dmem_req   = (state_q == ST_ACCESS);
  assign stall_mem  = dmem_req & ~dmem_ack;
  assign dmem_we    = ex_mem_q.memwrite;
  assign dmem_addr  = {ex_mem_q.alu[31:2], 2'b00};

  mem_align u_align (
    .funct3     (ex_mem_q.funct3),
    .addr_lo    (ex_mem_q.alu[1:0]),
    .store_data (ex_mem_q.wdata),
    .load_word  (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  // ACCESS tracks "EX/MEM holds an unacknowledged access"; the ack edge may load the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ex_access) state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ack) state_d = ex_access ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall_mem) begin
      ex_mem_d = '{alu: ALUResult_ex, wdata: MemWriteData_ex, rd: rdAddr_ex,
                   regwrite: RegWrite_ex, memread: MemRead_ex, memwrite: MemWrite_ex,
                   funct3: funct3_ex};
    end
  end

  // A stalled cycle retires a bubble; other writeback fields hold.
  always_comb begin
    mem_wb_d          = mem_wb_q;
    mem_wb_d.regwrite = 1'b0;
    if (!stall_mem) begin
      mem_wb_d.data     = is_load ? load_data : ex_mem_q.alu;
      mem_wb_d.rd       = ex_mem_q.rd;
      mem_wb_d.regwrite = ex_mem_q.regwrite & ~misaligned;
    end
  end

  // NOTE: state registers use non-blocking assignments with a synchronous reset tested first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

  assign ALUResult_mem   = ex_mem_q.alu;
  assign rdAddr_mem      = ex_mem_q.rd;
  assign RegWrite_mem    = ex_mem_q.regwrite;
  assign RegWriteData_wb = mem_wb_q.data;
  assign rdAddr_wb       = mem_wb_q.rd;
  assign RegWrite_wb     = mem_wb_q.regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: stores, loads with waits, back-to-back ops, reset abort.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem, stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_mem;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ack_count = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .rdAddr_ex       (rdAddr_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .funct3_ex       (funct3_ex),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .stall_mem       (stall_mem),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_mem    (misalign_mem),
`endif
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb)
  );

  // Completed handshakes seen on the memory port.
  always @(posedge clk) if (!reset && dmem_req && dmem_ack) ack_count <= ack_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    ALUResult_ex = alu; MemWriteData_ex = wd; rdAddr_ex = rd;
    RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; funct3_ex = f3;
  endtask

  task automatic nop();
    set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, F3_B);
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_ex(32'h100, 32'h1, 5'd3, 1'b1, 1'b1, 1'b0, F3_W);
    tick(); tick();
    reset = 1'b0; nop(); #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", dmem_req); end
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall_mem); end
    n_checks++; if (ALUResult_mem !== 32'h0 || rdAddr_mem !== 5'd0 || RegWrite_mem !== 1'b0) begin
      n_fail++; $display("FAIL rst_fwd: got %h/%0d/%0b want 0/0/0", ALUResult_mem, rdAddr_mem, RegWrite_mem); end
    n_checks++; if (RegWriteData_wb !== 32'h0 || rdAddr_wb !== 5'd0 || RegWrite_wb !== 1'b0) begin
      n_fail++; $display("FAIL rst_wb: got %h/%0d/%0b want 0/0/0", RegWriteData_wb, rdAddr_wb, RegWrite_wb); end
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++; if (misalign_mem !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %0b want 0", misalign_mem); end
`endif
  endtask

  task automatic test_sw();
    set_ex(32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, F3_W);
    tick();
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sw_req_we: got %0b/%0b want 1/1", dmem_req, dmem_we); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", dmem_addr); end
    n_checks++; if (dmem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", dmem_be); end
    n_checks++; if (dmem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
    dmem_ack = 1'b1; nop(); #1;
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL sw_zero_wait_stall: got %0b want 0", stall_mem); end
    tick(); dmem_ack = 1'b0; #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL sw_req_drop: got %0b want 0", dmem_req); end
  endtask

  task automatic test_sb();
    set_ex(32'h103, 32'h000000A5, 5'd0, 1'b0, 1'b0, 1'b1, F3_B);
    tick();
    n_checks++; if (dmem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", dmem_be); end
    n_checks++; if (dmem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", dmem_wdata); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h want 00000100", dmem_addr); end
    dmem_ack = 1'b1; nop();
    tick(); dmem_ack = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    set_ex(32'h12345678, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, F3_W);
    tick();
    n_checks++; if (ALUResult_mem !== 32'h12345678 || rdAddr_mem !== 5'd3 || RegWrite_mem !== 1'b1) begin
      n_fail++; $display("FAIL alu_fwd: got %h/%0d/%0b want 12345678/3/1", ALUResult_mem, rdAddr_mem, RegWrite_mem); end
    n_checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL alu_noreq: got %0b/%0b want 0/0", dmem_req, stall_mem); end
    nop(); tick();
    n_checks++; if (RegWriteData_wb !== 32'h12345678 || rdAddr_wb !== 5'd3 || RegWrite_wb !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb: got %h/%0d/%0b want 12345678/3/1", RegWriteData_wb, rdAddr_wb, RegWrite_wb); end
  endtask

  task automatic test_lb_wait();
    set_ex(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, F3_W);
    tick();
    set_ex(32'h102, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, F3_B);
    tick();
    nop();
    n_checks++; if (RegWrite_wb !== 1'b1 || RegWriteData_wb !== 32'h55) begin
      n_fail++; $display("FAIL lb_prev_wb: got %0b/%h want 1/00000055", RegWrite_wb, RegWriteData_wb); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL lb_stall%0d: got %0b want 1", i, stall_mem); end
      tick();
      n_checks++; if (RegWrite_wb !== 1'b0) begin n_fail++; $display("FAIL lb_bubble%0d: got %0b want 0", i, RegWrite_wb); end
      n_checks++; if (ALUResult_mem !== 32'h102) begin n_fail++; $display("FAIL lb_hold%0d: got %h want 00000102", i, ALUResult_mem); end
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h12C34567; #1;
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL lb_ack_stall: got %0b want 0", stall_mem); end
    tick(); dmem_ack = 1'b0;
    n_checks++; if (RegWriteData_wb !== 32'hFFFFFFC3 || rdAddr_wb !== 5'd5 || RegWrite_wb !== 1'b1) begin
      n_fail++; $display("FAIL lb_data: got %h/%0d/%0b want ffffffc3/5/1", RegWriteData_wb, rdAddr_wb, RegWrite_wb); end
  endtask

  task automatic test_lhu_lh();
    set_ex(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F3_HU);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h80010000;
    set_ex(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F3_H);
    tick();
    n_checks++; if (RegWriteData_wb !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", RegWriteData_wb); end
    n_checks++; if (dmem_req !== 1'b1 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL lh_req: got %0b/%0b want 1/0", dmem_req, stall_mem); end
    nop(); tick(); dmem_ack = 1'b0;
    n_checks++; if (RegWriteData_wb !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h want ffff8001", RegWriteData_wb); end
  endtask

  task automatic test_back_to_back();
    int acks_before;
    acks_before = ack_count;
    set_ex(32'h200, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, F3_W);
    tick();
    set_ex(32'h200, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, F3_W);
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall_mem !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sw_req: got %0b/%0b/%0b want 1/1/1", dmem_req, dmem_we, stall_mem); end
    tick();
    n_checks++; if (ALUResult_mem !== 32'h200 || dmem_wdata !== 32'hCAFEF00D || dmem_we !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sw_hold: got %h/%h/%0b want 00000200/cafef00d/1", ALUResult_mem, dmem_wdata, dmem_we); end
    dmem_ack = 1'b1; #1;
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL b2b_sw_ack: got %0b want 0", stall_mem); end
    tick(); dmem_ack = 1'b0; nop(); #1;
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h200 || stall_mem !== 1'b1) begin
      n_fail++; $display("FAIL b2b_lw_req: got %0b/%0b/%h/%0b want 1/0/00000200/1", dmem_req, dmem_we, dmem_addr, stall_mem); end
    tick();
    n_checks++; if (ALUResult_mem !== 32'h200 || RegWrite_wb !== 1'b0) begin
      n_fail++; $display("FAIL b2b_lw_hold: got %h/%0b want 00000200/0", ALUResult_mem, RegWrite_wb); end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick(); dmem_ack = 1'b0;
    n_checks++; if (RegWriteData_wb !== 32'hCAFEF00D || rdAddr_wb !== 5'd8 || RegWrite_wb !== 1'b1) begin
      n_fail++; $display("FAIL b2b_lw_data: got %h/%0d/%0b want cafef00d/8/1", RegWriteData_wb, rdAddr_wb, RegWrite_wb); end
    n_checks++; if (ack_count - acks_before !== 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", ack_count - acks_before); end
  endtask

  task automatic test_reset_mid_access();
    set_ex(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, F3_W);
    tick(); nop(); tick();
    n_checks++; if (dmem_req !== 1'b1 || stall_mem !== 1'b1) begin n_fail++; $display("FAIL rma_pending: got %0b/%0b want 1/1", dmem_req, stall_mem); end
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    n_checks++; if (dmem_req !== 1'b0 || RegWrite_wb !== 1'b0 || ALUResult_mem !== 32'h0) begin
      n_fail++; $display("FAIL rma_abort: got %0b/%0b/%h want 0/0/0", dmem_req, RegWrite_wb, ALUResult_mem); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rma_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00; #1;
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL rma_late_ack_stall: got %0b want 0", stall_mem); end
    tick(); dmem_ack = 1'b0;
    n_checks++; if (RegWrite_wb !== 1'b0 || RegWriteData_wb !== 32'h0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL rma_late_ack: got %0b/%h/%0b want 0/0/0", RegWrite_wb, RegWriteData_wb, dmem_req); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    set_ex(32'h101, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, F3_W);
    tick(); nop();
    n_checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL mis_noreq: got %0b/%0b want 0/0", dmem_req, stall_mem); end
    tick();
    n_checks++; if (misalign_mem !== 1'b1 || RegWrite_wb !== 1'b0) begin
      n_fail++; $display("FAIL mis_flag: got %0b/%0b want 1/0", misalign_mem, RegWrite_wb); end
    tick();
    n_checks++; if (misalign_mem !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %0b want 0", misalign_mem); end
  endtask
`endif

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_alu_passthrough();
    test_lb_wait();
    test_lhu_lh();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
